// File: rtl/uart_ns_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its picker.
package uart_ns_tx_arb_pkg;

    localparam int UART_DATA_SIZE   = 8;
    localparam int UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } type_uart_arb_states_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_ns_tx_arb_rr_pick.sv
// Combinational round-robin picker: first eligible request at or above ptr, with wrap.
module uart_rr_pick
    import uart_ns_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);

    logic [NUM_REQ-1:0] eligible;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = req[gi] & mask[gi];
        end
    endgenerate

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        int cand;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_any && eligible[cand]) begin
                gnt_any   = 1'b1;
                gnt_idx   = IW'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_ns_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// One byte is accepted, issued to the transmitter, and its whole frame is tracked
// before the next arbitration. A requester holding req_lock_i keeps the grant.
module uart_ns_tx_arb
    import uart_ns_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int ISSUE_TIMEOUT = 16,
    localparam int IW            = clog2_min1(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*UART_DATA_SIZE-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]                req_lock_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [UART_DATA_SIZE-1:0]         tx_data_o,
    output logic                              tx_valid_o,
    input  logic                              tx_ready_i,
    output logic [IW-1:0]                     grant_id_o,
    output logic                              busy_o,
    output logic                              timeout_o
);

    localparam int            TW          = $clog2(ISSUE_TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_MAX    = '1;
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(ISSUE_TIMEOUT);

    type_uart_arb_states_e     state_reg, state_next;
    logic [IW-1:0]             rr_reg, rr_next;
    logic                      lock_valid_reg, lock_valid_next;
    logic [UART_DATA_SIZE-1:0] data_reg, data_next;
    logic [IW-1:0]             grant_id_reg, grant_id_next;
    logic                      timeout_reg, timeout_next;
    logic [TW-1:0]             tcnt_reg, tcnt_next;
    logic [NUM_REQ-1:0]        req_ready_next;

    logic [UART_DATA_SIZE-1:0] req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]        lock_mask;
    logic [NUM_REQ-1:0]        pick_gnt;
    logic [IW-1:0]             pick_idx;
    logic                      pick_any;
    logic [TW-1:0]             tcnt_inc;

    // Unpack the byte lanes; while a lock is held only its owner (last grantee) is eligible.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign req_bytes[gi] = req_data_i[gi*UART_DATA_SIZE +: UART_DATA_SIZE];
            assign lock_mask[gi] = !lock_valid_reg || (grant_id_reg == IW'(gi));
        end
    endgenerate

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_valid_i),
        .ptr     (rr_reg),
        .mask    (lock_mask),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign tcnt_inc = (tcnt_reg == TCNT_MAX) ? tcnt_reg : tcnt_reg + TW'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            rr_reg         <= '0;
            lock_valid_reg <= 1'b0;
            data_reg       <= '0;
            grant_id_reg   <= '0;
            timeout_reg    <= 1'b0;
            tcnt_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            rr_reg         <= rr_next;
            lock_valid_reg <= lock_valid_next;
            data_reg       <= data_next;
            grant_id_reg   <= grant_id_next;
            timeout_reg    <= timeout_next;
            tcnt_reg       <= tcnt_next;
        end
    end

    // Next-state logic: accept in IDLE, hold the byte through ISSUE, track the frame in WAIT_DONE.
    always_comb begin
        state_next      = state_reg;
        rr_next         = rr_reg;
        lock_valid_next = lock_valid_reg;
        data_next       = data_reg;
        grant_id_next   = grant_id_reg;
        timeout_next    = timeout_reg;
        tcnt_next       = tcnt_reg;
        req_ready_next  = '0;
        case (state_reg)
            ARB_IDLE: begin
                if (tx_ready_i && pick_any) begin
                    req_ready_next  = pick_gnt;
                    data_next       = req_bytes[pick_idx];
                    grant_id_next   = pick_idx;
                    lock_valid_next = req_lock_i[pick_idx];
                    if (!req_lock_i[pick_idx]) begin
                        rr_next = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
                    end
                    tcnt_next  = '0;
                    state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (!tx_ready_i) begin
                    tcnt_next  = '0;
                    state_next = ARB_WAIT_DONE;
                end else if (tcnt_inc == TIMEOUT_VAL) begin
                    // Transmitter never went busy: drop the byte and free any lock.
                    timeout_next    = 1'b1;
                    lock_valid_next = 1'b0;
                    tcnt_next       = '0;
                    state_next      = ARB_IDLE;
                end else begin
                    tcnt_next = tcnt_inc;
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_ready_i) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Accept pulse is combinational from IDLE and forced low while reset is held.
    assign req_ready_o = req_ready_next & {NUM_REQ{rst_n}};
    assign tx_valid_o  = (state_reg == ARB_ISSUE);
    assign tx_data_o   = data_reg;
    assign grant_id_o  = grant_id_reg;
    assign busy_o      = (state_reg != ARB_IDLE);
    assign timeout_o   = timeout_reg;

endmodule

// File: tb/tb_uart_ns_tx_arb.sv
// Directed bench for uart_ns_tx_arb with a behavioural transmitter (baud divider 4).
module tb_uart_ns_tx_arb;
    import uart_ns_tx_arb_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N*8-1:0] req_data_i = '0;
    logic [N-1:0]   req_lock_i = '0;
    logic [N-1:0]   req_ready_o;
    logic [7:0]     tx_data_o;
    logic           tx_valid_o;
    logic           tx_ready_i;
    logic [1:0]     grant_id_o;
    logic           busy_o;
    logic           timeout_o;

    int total = 0;
    int bad   = 0;

    // Transmitter model: sees valid, samples data one cycle later, then busy for 10 bits x 4 cycles.
    logic       stuck = 1'b0;
    logic [1:0] m_state;
    logic [9:0] m_shift;
    logic [9:0] m_rx;
    logic [3:0] m_bit;
    logic [1:0] m_div;
    logic [7:0] sent_q [$];

    always #5 clk = ~clk;

    uart_ns_tx_arb #(
        .NUM_REQ       (N),
        .ISSUE_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_lock_i  (req_lock_i),
        .req_ready_o (req_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    assign tx_ready_i = stuck | (m_state != 2'd2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 2'd0;
            m_shift <= '0;
            m_rx    <= '0;
            m_bit   <= '0;
            m_div   <= '0;
        end else if (stuck) begin
            m_state <= 2'd0;
        end else begin
            case (m_state)
                2'd0: if (tx_valid_o) m_state <= 2'd1;
                2'd1: begin
                    m_shift <= {1'b1, tx_data_o, 1'b0};
                    m_bit   <= '0;
                    m_div   <= '0;
                    m_state <= 2'd2;
                end
                default: begin
                    m_div <= m_div + 2'd1;
                    if (m_div == 2'd1) m_rx <= {m_shift[m_bit], m_rx[9:1]};
                    if (m_div == 2'd3) begin
                        m_bit <= m_bit + 4'd1;
                        if (m_bit == 4'd9) begin
                            m_state <= 2'd0;
                            sent_q.push_back(m_rx[8:1]);
                        end
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        logic [31:0] v;
        v = (sent_q.size() != 0) ? {24'h0, sent_q.pop_front()} : 32'hFFFF_FFFF;
        chk(tag, v, {24'h0, exp});
    endtask

    task automatic wait_accept(input string tag, output int idx);
        bit got;
        got = 1'b0;
        idx = -1;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (req_ready_o != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_seen"}, got, 1);
        if (got) begin
            chk({tag, "_onehot"}, $countones(req_ready_o), 1);
            for (int i = 0; i < N; i++) if (req_ready_o[i]) idx = i;
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1;
            if (!busy_o && tx_ready_i) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_idle"}, done, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        stuck       = 1'b0;
        req_valid_i = '0;
        req_lock_i  = '0;
        repeat (2) @(negedge clk);
        sent_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        bit stable;
        bit seen_wait;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_grant", grant_id_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_ready", req_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte 0x55 from requester 0
        @(negedge clk);
        req_data_i[7:0] = 8'h55;
        req_valid_i     = 4'b0001;
        wait_accept("t1_acc", idx);
        chk("t1_idx", idx, 0);
        @(negedge clk);
        req_valid_i = '0;
        #1;
        chk("t1_valid_t1", tx_valid_o, 1);
        chk("t1_data_t1", tx_data_o, 8'h55);
        chk("t1_ready_pulse", req_ready_o, 0);
        chk("t1_busy_t1", busy_o, 1);
        @(negedge clk); #1;
        chk("t1_valid_t2", tx_valid_o, 1);
        @(negedge clk); #1;
        chk("t1_valid_t3", tx_valid_o, 1);
        chk("t1_txbusy_t3", tx_ready_i, 0);
        @(negedge clk); #1;
        chk("t1_valid_t4", tx_valid_o, 0);
        chk("t1_busy_t4", busy_o, 1);
        wait_idle("t1");
        chk("t1_busy_end", busy_o, 0);
        chk("t1_grant_end", grant_id_o, 0);
        pop_chk("t1_line", 8'h55);

        // Fairness: all valid, no lock
        do_reset();
        req_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid_i = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_accept("fair_acc", idx);
            chk("fair_idx", idx, k % 4);
            @(negedge clk); #1;
            chk("fair_pulse", req_ready_o, 0);
        end
        req_valid_i = '0;
        wait_idle("fair");
        for (int k = 0; k < 6; k++) pop_chk("fair_line", 8'hA0 + 8'(k % 4));

        // Lock: requester 2 sends three contiguous bytes
        do_reset();
        req_data_i  = {8'hB3, 8'h11, 8'hB1, 8'hB0};
        req_lock_i  = 4'b0100;
        req_valid_i = 4'b0100;
        wait_accept("lock_acc1", idx);
        chk("lock_idx1", idx, 2);
        @(negedge clk);
        req_data_i[23:16] = 8'h22;
        req_valid_i       = 4'b1111;
        wait_accept("lock_acc2", idx);
        chk("lock_idx2", idx, 2);
        @(negedge clk);
        req_data_i[23:16] = 8'h33;
        req_lock_i        = 4'b0000;
        wait_accept("lock_acc3", idx);
        chk("lock_idx3", idx, 2);
        @(negedge clk);
        req_valid_i = 4'b1011;
        wait_accept("lock_acc4", idx);
        chk("lock_idx4", idx, 3);
        @(negedge clk);
        req_valid_i = 4'b0011;
        wait_accept("lock_acc5", idx);
        chk("lock_idx5", idx, 0);
        @(negedge clk);
        req_valid_i = '0;
        wait_idle("lock");
        pop_chk("lock_line1", 8'h11);
        pop_chk("lock_line2", 8'h22);
        pop_chk("lock_line3", 8'h33);
        pop_chk("lock_line4", 8'hB3);
        pop_chk("lock_line5", 8'hB0);

        // Data stability after accept
        do_reset();
        req_data_i[7:0] = 8'h5A;
        req_valid_i     = 4'b0001;
        wait_accept("stab_acc", idx);
        chk("stab_idx", idx, 0);
        @(negedge clk);
        req_data_i[7:0] = 8'hFF;
        req_valid_i     = '0;
        #1;
        chk("stab_data_t1", tx_data_o, 8'h5A);
        stable    = 1'b1;
        seen_wait = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #1;
            if (!busy_o) break;
            if (tx_data_o !== 8'h5A) stable = 1'b0;
            if (!tx_valid_o) seen_wait = 1'b1;
        end
        chk("stab_held", stable, 1);
        chk("stab_wait_seen", seen_wait, 1);
        wait_idle("stab");
        pop_chk("stab_line", 8'h5A);

        // Timeout with a stuck transmitter, locked grant
        do_reset();
        stuck            = 1'b1;
        req_data_i[15:8] = 8'h77;
        req_lock_i       = 4'b0010;
        req_valid_i      = 4'b0010;
        wait_accept("to_acc", idx);
        chk("to_idx", idx, 1);
        @(negedge clk);
        req_valid_i = '0;
        req_lock_i  = '0;
        repeat (15) @(negedge clk);
        #1;
        chk("to_valid_t16", tx_valid_o, 1);
        chk("to_flag_t16", timeout_o, 0);
        @(negedge clk); #1;
        chk("to_valid_t17", tx_valid_o, 0);
        chk("to_flag_t17", timeout_o, 1);
        chk("to_busy_t17", busy_o, 0);
        stuck           = 1'b0;
        req_data_i[7:0] = 8'h99;
        req_valid_i     = 4'b0001;
        wait_accept("to_acc2", idx);
        chk("to_idx2", idx, 0);
        @(negedge clk);
        req_valid_i = '0;
        wait_idle("to");
        chk("to_sticky", timeout_o, 1);
        pop_chk("to_line", 8'h99);
        chk("to_no_extra", sent_q.size(), 0);

        // Reset during WAIT_DONE
        do_reset();
        req_data_i[23:16] = 8'h3C;
        req_valid_i       = 4'b0100;
        wait_accept("mr_acc", idx);
        chk("mr_idx", idx, 2);
        @(negedge clk);
        req_valid_i = '0;
        repeat (5) @(negedge clk);
        #1;
        chk("mr_in_wait_busy", busy_o, 1);
        chk("mr_in_wait_valid", tx_valid_o, 0);
        rst_n           = 1'b0;
        req_data_i[7:0] = 8'hC0;
        req_valid_i     = 4'b1111;
        #1;
        chk("mr_data", tx_data_o, 0);
        chk("mr_valid", tx_valid_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_grant", grant_id_o, 0);
        chk("mr_ready", req_ready_o, 0);
        sent_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_accept("mr_acc2", idx);
        chk("mr_idx2", idx, 0);
        @(negedge clk);
        req_valid_i = '0;
        wait_idle("mr");
        pop_chk("mr_line", 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_ns_tx_arb.md
Name: uart_ns_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one uart_ns_tx transmitter between NUM_REQ byte-producing requesters (e.g. core console, debug monitor, DMA drain).
- Accepts one byte at a time from the granted requester.
- Drives the transmitter's valid/data inputs and tracks its ready (not-busy) output through a full frame before re-arbitrating.
- Optional per-requester lock keeps multi-byte messages contiguous on the line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ISSUE_TIMEOUT, 16, max cycles tx_valid_o may stay high without tx_ready_i falling before the issue is aborted.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid_i  input  NUM_REQ  per-requester byte valid
- req_data_i  input  NUM_REQ*UART_DATA_SIZE  per-requester byte; requester i occupies bits [i*8 +: 8]
- req_lock_i  input  NUM_REQ  hold grant after this byte while asserted
- req_ready_o  output  NUM_REQ  one-hot accept pulse
- tx_data_o  output  UART_DATA_SIZE  to transmitter tx_data_i
- tx_valid_o  output  1  to transmitter valid_i
- tx_ready_i  input  1  from transmitter ready_o (high = not busy)
- grant_id_o  output  $clog2(NUM_REQ)  index of the current or last owner
- busy_o  output  1  state != ARB_IDLE
- timeout_o  output  1  sticky; set on issue abort; cleared only by reset

Behaviour:
- Reset (async, rst_n low):
  - State ARB_IDLE; rr pointer 0; lock_owner_valid 0.
  - req_ready_o 0, tx_valid_o 0, tx_data_o 0, grant_id_o 0, busy_o 0, timeout_o 0, timeout counter 0.
  - Reset mid-frame drops the byte; the transmitter has its own reset.
- States: ARB_IDLE, ARB_ISSUE, ARB_WAIT_DONE (shared enum type_uart_arb_states_e).
- ARB_IDLE:
  - Acts only when tx_ready_i=1.
  - If lock_owner_valid, only the lock owner is eligible; otherwise the first valid requester scanning from rr pointer upward, with wrap.
  - On a winner w in cycle T: req_ready_o[w]=1 for exactly that cycle; latch req_data_i[w] into the data register; grant_id_o<=w; go to ARB_ISSUE at T+1.
  - lock_owner_valid<=req_lock_i[w] (owner w).
  - rr pointer<=(w+1) mod NUM_REQ on non-locked grants; rr pointer is unchanged while a lock is held.
  - No eligible request, or tx_ready_i=0: stay, all outputs idle.
- ARB_ISSUE:
  - tx_valid_o=1 and tx_data_o=latched byte; both held stable every cycle in this state.
  - The transmitter samples data one cycle after it sees valid, so data must not change until busy is observed.
  - tx_ready_i=0 observed → tx_valid_o drops next cycle; go to ARB_WAIT_DONE; clear the timeout counter.
  - Counter reaches ISSUE_TIMEOUT → set timeout_o; clear lock_owner_valid; go to ARB_IDLE; the byte is dropped.
- ARB_WAIT_DONE:
  - tx_valid_o=0; tx_data_o held.
  - Wait for tx_ready_i=1, then go to ARB_IDLE.
  - Re-arbitration can happen in that same IDLE cycle (earliest next accept is 1 cycle after the frame ends).
- Lock release:
  - The owner deasserts req_lock_i on its final byte; the grant is freed after that byte.
  - If the owner drops req_valid_i while locked, the arbiter waits indefinitely; no preemption.
- tx_data_o changes only on an IDLE accept.
- Latency, accept to line: T accept, T+1 tx_valid_o, T+2 transmitter START, T+3 busy; start bit on the line from T+3.
- Simultaneous valid from every requester with no locks: grants rotate i, i+1, …; each requester gets 1 byte per NUM_REQ frames.
- grant_id_o holds its value after completion.
- Width: timeout counter $clog2(ISSUE_TIMEOUT+1) bits, saturating.

Decomposition:
- uart_defs package additions: type_uart_arb_states_e; UART_ARB_MAX_REQ=8.
- Reuse UART_DATA_SIZE from the package.
- One sub-module: uart_rr_pick. Combinational round-robin picker taking the request vector, pointer, and lock mask; outputs a one-hot grant and its index. Kept separate so it can be reused by the RX/interrupt paths.

Test Plan:
- Single byte: req_valid_i=4'b0001, data 0x55; tx_ready_i follows a model uart_ns_tx (baud_div 4) → req_ready_o[0] pulses at T; tx_valid_o high T+1..T+3; line shows 0x55 LSB-first; busy_o low after frame; grant_id_o=0.
- Fairness: all 4 valid continuously, distinct bytes 0xA0+i, no lock → transmit order 0,1,2,3,0,1; each req_ready_o pulse 1 cycle, exactly one per frame.
- Lock: req 2 sends 3 bytes with lock high on the first 2 while req 0,1,3 also valid → bytes from 2 back-to-back; next grant goes to 3.
- Data stability: req_data_i[0] changes the cycle after accept → tx_data_o keeps the original value through ARB_WAIT_DONE; the frame carries the original byte.
- Timeout: tx_ready_i held 1 (stuck transmitter) → after 16 cycles in ARB_ISSUE, timeout_o=1 sticky, state ARB_IDLE, lock cleared; the next request is still serviced.
- Reset mid-frame: rst_n low during ARB_WAIT_DONE → all outputs 0 immediately; after release, rr pointer 0 and requester 0 is granted first.
